regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port (wa3/wd3/we3) among N_REQ writers
//  (ALU writeback, load writeback, I/O input) using round-robin arbitration.
//  Sweeps r1..r15 to zero after reset or on a clear request, then serves writers.
//  Sits between the writeback sources and the register file. Its outputs drive
//  wa3/wd3/we3 directly.
// PARAMETERS
//  N_REQ  3   number of write requesters (2..8)
//  DW     16  data width, matching wd3
//  AW     4   register address width; the file holds 2**AW registers, r0 hardwired 0
//  CLEAR_ON_RESET 1  1: enter CLEAR after rst; 0: enter RUN directly
// PORTS
//  clk     in   1         rising-edge clock, shared with the register file
//  rst     in   1         synchronous, active-high reset
//  clr     in   1         pulse: re-run the zero sweep
//  req     in   N_REQ     per-requester write request; held until gnt
//  waddr   in   N_REQ*AW  per-requester destination; slice i = [i*AW +: AW]
//  wdata   in   N_REQ*DW  per-requester data; slice i = [i*DW +: DW]
//  gnt     out  N_REQ     one-hot, combinational; request i consumed at this edge
//  wa3     out  AW        registered write address to the register file
//  wd3     out  DW        registered write data to the register file
//  we3     out  1         registered write enable to the register file
//  busy    out  1         1 while in CLEAR; requesters are never granted
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=CLEAR (or RUN if CLEAR_ON_RESET=0).
//    Also clr_idx=1, rr_ptr=N_REQ-1 so requester 0 has top priority, and
//    wa3=0, wd3=0, we3=0.
//  - busy = (state==CLEAR), decoded combinationally from state.
//  - CLEAR state, one write per cycle:
//      next-cycle wa3=clr_idx, wd3=0, we3=1.
//      clr_idx increments each cycle. After the write of index 2**AW-1,
//      state goes to RUN and clr_idx returns to 1. Sweep length is 2**AW-1 cycles.
//      gnt=0 throughout. clr during CLEAR is ignored.
//  - RUN state:
//      gnt = round-robin pick among req; search starts at rr_ptr+1 mod N_REQ.
//      At the edge where gnt[i]=1:
//        wa3<=waddr_i, wd3<=wdata_i, we3<=(waddr_i!=0), rr_ptr<=i.
//      With no request: we3<=0; wa3/wd3 hold their values.
//      Latency: gnt in cycle n -> we3 high in cycle n+1 -> register written at end of n+1.
//      A requester holding req high after gnt is a new request. Back-to-back grants
//      to one lone requester are allowed, one per cycle.
//  - Write to r0: the request is granted and consumed, but we3 stays 0. No stall.
//  - clr=1 in RUN: grants in that cycle still complete. Next state is CLEAR with
//    clr_idx=1. A write already registered reaches the file before the sweep.
//  - rst during CLEAR: the sweep restarts at r1. rst takes priority over clr.
//  - Fairness: every continuously-asserted req is granted within N_REQ cycles.
// STRUCTURE
//  - Package regfile_pkg holds:
//      constants RF_AW=4, RF_DW=16, RF_ZERO_ADDR='0
//      typedef rf_state_e {RF_CLEAR, RF_RUN}
//      typedef rf_addr_t
//  - Sub-module rr_arbiter (parameter N; inputs req, ptr, en; outputs gnt one-hot
//    and idx). It is purely combinational.
//  - The top level holds the FSM, clr_idx counter, rr_ptr register, per-requester
//    slice mux and output registers.
// TESTING
//  1. rst 1 cycle, no req -> 15 cycles of we3=1, wa3=1..15, wd3=0, busy=1;
//     then busy=0, we3=0.
//  2. RUN, req=3'b111 held, waddr=5/6/7 -> gnt 001,010,100,001...;
//     wa3 5,6,7,5 one cycle later.
//  3. RUN, req0 only, waddr=0, wdata=16'hBEEF -> gnt[0]=1 for one cycle;
//     we3 stays 0; wa3=0.
//  4. req1 alone for 4 cycles, waddr=3, wdata=1,2,3,4 -> gnt[1] every cycle;
//     wd3 1..4 at cycles n+1..n+4.
//  5. clr with req2 (waddr=9) in the same cycle -> gnt[2]=1, write r9 next cycle;
//     then busy=1 and 15 zero writes; req1 held -> granted the first RUN cycle.
//  6. rst asserted at the 7th sweep cycle -> sweep restarts at wa3=1;
//     exactly 15 zero writes follow the reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register-file write path
package regfile_pkg;

   localparam int RF_AW = 4;
   localparam int RF_DW = 16;
   localparam logic [RF_AW-1:0] RF_ZERO_ADDR = '0;

   typedef logic [RF_AW-1:0] rf_addr_t;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_e;

   // Width of an index able to name any of n requesters (at least one bit).
   function automatic int rf_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, search starts after ptr
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = rf_idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   // Walk N candidates starting at ptr+1 (wrapping); the first asserted request wins.
   always_comb begin
      int   cand;
      logic found;
      gnt   = '0;
      idx   = '0;
      cand  = 0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (en && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin sharing of the register-file write port with zero sweep
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int N_REQ          = 3,
   parameter int DW             = RF_DW,
   parameter int AW             = RF_AW,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*AW-1:0] waddr,
   input  logic [N_REQ*DW-1:0] wdata,
   output logic [N_REQ-1:0]    gnt,
   output logic [AW-1:0]       wa3,
   output logic [DW-1:0]       wd3,
   output logic                we3,
   output logic                busy
);

   localparam int IW = rf_idx_width(N_REQ);

   // r0 is hardwired, so the sweep covers r1 .. r(2**AW-1).
   localparam logic [AW-1:0] FIRST_IDX = AW'(1);
   localparam logic [AW-1:0] LAST_IDX  = '1;

   // Pointer parked on the last requester so requester 0 wins first after reset.
   localparam logic [IW-1:0] PTR_RESET = IW'(N_REQ - 1);

   localparam rf_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? RF_CLEAR : RF_RUN;

   rf_state_e       state, state_nx;
   logic [AW-1:0]   clr_idx, clr_idx_nx;
   logic [IW-1:0]   rr_ptr, rr_ptr_nx;
   logic [AW-1:0]   wa3_nx;
   logic [DW-1:0]   wd3_nx;
   logic            we3_nx;

   logic            arb_en;
   logic [IW-1:0]   gnt_idx;
   logic            any_gnt;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   // Requesters are only eligible while the sweep is not running.
   assign arb_en  = (state == RF_RUN);
   assign busy    = (state == RF_CLEAR);
   assign any_gnt = |gnt;

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IW)
   ) u_arb (
      .req (req),
      .ptr (rr_ptr),
      .en  (arb_en),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   // Pick the address/data slice belonging to the granted requester (gnt is one-hot).
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = waddr[i*AW +: AW];
            sel_data = wdata[i*DW +: DW];
         end
      end
   end

   // Next-state, sweep counter, fairness pointer and write-port values.
   always_comb begin
      state_nx   = state;
      clr_idx_nx = clr_idx;
      rr_ptr_nx  = rr_ptr;
      wa3_nx     = wa3;
      wd3_nx     = wd3;
      we3_nx     = 1'b0;
      case (state)
         RF_CLEAR: begin
            // One zero write per cycle; clr is ignored while sweeping.
            wa3_nx = clr_idx;
            wd3_nx = '0;
            we3_nx = 1'b1;
            if (clr_idx == LAST_IDX) begin
               state_nx   = RF_RUN;
               clr_idx_nx = FIRST_IDX;
            end else begin
               clr_idx_nx = clr_idx + AW'(1);
            end
         end
         RF_RUN: begin
            // A write to r0 is still consumed (and advances fairness) but never enabled.
            if (any_gnt) begin
               wa3_nx    = sel_addr;
               wd3_nx    = sel_data;
               we3_nx    = (sel_addr != '0);
               rr_ptr_nx = gnt_idx;
            end
            // The grant of this cycle still lands before the sweep starts.
            if (clr) begin
               state_nx   = RF_CLEAR;
               clr_idx_nx = FIRST_IDX;
            end
         end
         default: begin
            state_nx   = RESET_STATE;
            clr_idx_nx = FIRST_IDX;
         end
      endcase
   end

   // State and registered write-port outputs; rst restarts everything, including a sweep in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RESET_STATE;
         clr_idx <= FIRST_IDX;
         rr_ptr  <= PTR_RESET;
         wa3     <= '0;
         wd3     <= '0;
         we3     <= 1'b0;
      end else begin
         state   <= state_nx;
         clr_idx <= clr_idx_nx;
         rr_ptr  <= rr_ptr_nx;
         wa3     <= wa3_nx;
         wd3     <= wd3_nx;
         we3     <= we3_nx;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

   localparam int N_REQ = 3;
   localparam int DW    = 16;
   localparam int AW    = 4;

   logic                clk;
   logic                rst;
   logic                clr;
   logic [N_REQ-1:0]    req;
   logic [N_REQ*AW-1:0] waddr;
   logic [N_REQ*DW-1:0] wdata;
   logic [N_REQ-1:0]    gnt;
   logic [AW-1:0]       wa3;
   logic [DW-1:0]       wd3;
   logic                we3;
   logic                busy;

   int n_assert;
   int n_fail;

   regfile_write_arbiter #(
      .N_REQ          (N_REQ),
      .DW             (DW),
      .AW             (AW),
      .CLEAR_ON_RESET (1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .req   (req),
      .waddr (waddr),
      .wdata (wdata),
      .gnt   (gnt),
      .wa3   (wa3),
      .wd3   (wd3),
      .we3   (we3),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land 1 time unit after it.
   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_sweep_cycle(input int k, input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_gnt"}, 32'(gnt), 32'd0);
      edge_step();
      check({tag, "_we3"}, 32'(we3), 32'd1);
      check({tag, "_wa3"}, 32'(wa3), 32'(k));
      check({tag, "_wd3"}, 32'(wd3), 32'd0);
   endtask

   initial begin
      logic [2:0]  exp_gnt [4];
      logic [3:0]  exp_wa  [4];
      n_assert = 0;
      n_fail   = 0;
      rst   = 1'b1;
      clr   = 1'b0;
      req   = '0;
      waddr = '0;
      wdata = '0;

      // Test 1: reset then full zero sweep r1..r15
      edge_step();
      check("rst_wa3", 32'(wa3), 32'd0);
      check("rst_wd3", 32'(wd3), 32'd0);
      check("rst_we3", 32'(we3), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      for (int k = 1; k <= 15; k++) begin
         check_sweep_cycle(k, "t1_sweep");
      end
      check("t1_busy_done", 32'(busy), 32'd0);
      edge_step();
      check("t1_we3_idle", 32'(we3), 32'd0);
      check("t1_wa3_hold", 32'(wa3), 32'd15);

      // Test 2: all three requesting, rotation 0,1,2,0
      waddr[0*AW +: AW] = 4'd5;
      waddr[1*AW +: AW] = 4'd6;
      waddr[2*AW +: AW] = 4'd7;
      wdata[0*DW +: DW] = 16'h0100;
      wdata[1*DW +: DW] = 16'h0101;
      wdata[2*DW +: DW] = 16'h0102;
      req = 3'b111;
      exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
      exp_wa  = '{4'd5, 4'd6, 4'd7, 4'd5};
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t2_gnt", 32'(gnt), 32'(exp_gnt[k]));
         edge_step();
         check("t2_wa3", 32'(wa3), 32'(exp_wa[k]));
         check("t2_we3", 32'(we3), 32'd1);
      end
      check("t2_wd3_last", 32'(wd3), 32'h0100);

      // Test 3: write to r0 is granted but never enabled
      req = 3'b001;
      waddr[0*AW +: AW] = 4'd0;
      wdata[0*DW +: DW] = 16'hBEEF;
      #1;
      check("t3_gnt", 32'(gnt), 32'b001);
      edge_step();
      check("t3_we3", 32'(we3), 32'd0);
      check("t3_wa3", 32'(wa3), 32'd0);
      req = 3'b000;
      #1;
      check("t3_gnt_idle", 32'(gnt), 32'd0);
      edge_step();
      check("t3_we3_idle", 32'(we3), 32'd0);

      // Test 4: lone requester 1 granted back-to-back
      req = 3'b010;
      waddr[1*AW +: AW] = 4'd3;
      for (int k = 1; k <= 4; k++) begin
         wdata[1*DW +: DW] = 16'(k);
         #1;
         check("t4_gnt", 32'(gnt), 32'b010);
         edge_step();
         check("t4_wd3", 32'(wd3), 32'(k));
         check("t4_wa3", 32'(wa3), 32'd3);
         check("t4_we3", 32'(we3), 32'd1);
      end

      // Test 5: clr together with a grant; the grant lands, then the sweep
      req = 3'b100;
      waddr[2*AW +: AW] = 4'd9;
      wdata[2*DW +: DW] = 16'h0909;
      clr = 1'b1;
      #1;
      check("t5_gnt_clr", 32'(gnt), 32'b100);
      check("t5_busy_pre", 32'(busy), 32'd0);
      edge_step();
      check("t5_we3", 32'(we3), 32'd1);
      check("t5_wa3", 32'(wa3), 32'd9);
      check("t5_wd3", 32'(wd3), 32'h0909);
      clr = 1'b0;
      req = 3'b010;
      wdata[1*DW +: DW] = 16'h00AA;
      #1;
      for (int k = 1; k <= 15; k++) begin
         check_sweep_cycle(k, "t5_sweep");
      end
      check("t5_busy_done", 32'(busy), 32'd0);
      check("t5_gnt_first_run", 32'(gnt), 32'b010);
      edge_step();
      check("t5_wa3_run", 32'(wa3), 32'd3);
      check("t5_wd3_run", 32'(wd3), 32'h00AA);
      check("t5_we3_run", 32'(we3), 32'd1);
      req = 3'b000;

      // Test 6: rst in the 7th sweep cycle restarts the sweep; clr mid-sweep ignored
      clr = 1'b1;
      edge_step();
      clr = 1'b0;
      #1;
      for (int k = 1; k <= 6; k++) begin
         check_sweep_cycle(k, "t6_pre");
      end
      rst = 1'b1;
      clr = 1'b1;
      edge_step();
      check("t6_rst_we3", 32'(we3), 32'd0);
      check("t6_rst_wa3", 32'(wa3), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      clr = 1'b0;
      #1;
      for (int k = 1; k <= 15; k++) begin
         clr = (k == 5);
         #1;
         check_sweep_cycle(k, "t6_post");
      end
      clr = 1'b0;
      #1;
      check("t6_busy_done", 32'(busy), 32'd0);
      edge_step();
      check("t6_we3_idle", 32'(we3), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
